// File: rtl/uart_tx_arbiter.sv
// Serializes direction, seed-pair and control requests into single-cycle UART TX FIFO writes.
// FSM: IDLE grants a pending slot, GAP idles one cycle after each write, SEED_Y sends the seed Y byte.
module uart_tx_arbiter #(
  parameter int DIR_MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir_send,
  input  logic [2:0] dir,
  input  logic       seed_req,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  input  logic       ctrl_req,
  input  logic [5:0] ctrl_code,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       seed_drop,
  output logic       ctrl_drop
);
  localparam int WW = (DIR_MAX_WAIT < 1) ? 1 : $clog2(DIR_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(DIR_MAX_WAIT);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED_Y = 2'd1, GAP = 2'd2} state_t;

  state_t        state, state_n;
  logic          pair_open, pair_open_n;
  logic          dir_prev, dir_v, seed_v, ctrl_v;
  logic [2:0]    dir_q;
  logic [4:0]    x_q, y_q;
  logic [5:0]    ctrl_q;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic          grant_dir, grant_seed, grant_ctrl, issue_y;
  logic          wr_n;
  logic [7:0]    data_n;
  logic          dir_rise, seed_take, ctrl_take;
  logic          dir_v_n, seed_v_n, ctrl_v_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pair_open <= 1'b0;
    end else begin
      state     <= state_n;
      pair_open <= pair_open_n;
    end
  end

  // pair_open remembers that GAP must lead into SEED_Y rather than IDLE
  always_comb begin
    state_n     = state;
    pair_open_n = pair_open;
    case (state)
      IDLE: begin
        if (wr_n) begin
          state_n     = GAP;
          pair_open_n = grant_seed;
        end
      end
      GAP:     state_n = pair_open ? SEED_Y : IDLE;
      SEED_Y: begin
        if (issue_y) begin
          state_n     = GAP;
          pair_open_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_dir  = 1'b0;
    grant_seed = 1'b0;
    grant_ctrl = 1'b0;
    issue_y    = 1'b0;
    data_n     = w_data;
    if (state == IDLE && !tx_full) begin
      if (dir_v && wait_cnt == WAIT_MAX) grant_dir = 1'b1;
      else if (seed_v)                   grant_seed = 1'b1;
      else if (ctrl_v)                   grant_ctrl = 1'b1;
      else if (dir_v)                    grant_dir = 1'b1;
    end
    if (state == SEED_Y && !tx_full) issue_y = 1'b1;
    wr_n = grant_dir | grant_seed | grant_ctrl | issue_y;
    if (grant_dir)       data_n = {5'b00000, dir_q};
    else if (grant_seed) data_n = {3'b010, x_q};
    else if (grant_ctrl) data_n = {2'b11, ctrl_q};
    else if (issue_y)    data_n = {3'b100, y_q};
  end

  // a capture on the same edge as the slot's release is accepted, not dropped
  assign dir_rise  = dir_send & ~dir_prev;
  assign seed_take = seed_req & (~seed_v | issue_y);
  assign ctrl_take = ctrl_req & (~ctrl_v | grant_ctrl);
  assign dir_v_n   = dir_rise | (dir_v & ~grant_dir);
  assign seed_v_n  = seed_take | (seed_v & ~issue_y);
  assign ctrl_v_n  = ctrl_take | (ctrl_v & ~grant_ctrl);

  always_comb begin
    wait_cnt_n = wait_cnt;
    if (grant_dir || !dir_v)
      wait_cnt_n = '0;
    else if ((grant_seed || grant_ctrl) && wait_cnt != WAIT_MAX)
      wait_cnt_n = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_prev  <= 1'b0;
      dir_v     <= 1'b0;
      seed_v    <= 1'b0;
      ctrl_v    <= 1'b0;
      dir_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ctrl_q    <= '0;
      wait_cnt  <= '0;
      seed_drop <= 1'b0;
      ctrl_drop <= 1'b0;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      busy      <= 1'b0;
    end else begin
      dir_prev <= dir_send;
      dir_v    <= dir_v_n;
      seed_v   <= seed_v_n;
      ctrl_v   <= ctrl_v_n;
      if (dir_rise) dir_q <= dir;
      if (seed_take) begin
        x_q <= seed_x;
        y_q <= seed_y;
      end
      if (ctrl_take) ctrl_q <= ctrl_code;
      if (seed_req && !seed_take) seed_drop <= 1'b1;
      if (ctrl_req && !ctrl_take) ctrl_drop <= 1'b1;
      wait_cnt <= wait_cnt_n;
      wr_uart  <= wr_n;
      w_data   <= data_n;
      busy     <= dir_v_n | seed_v_n | ctrl_v_n | (state_n != IDLE);
    end
  end
endmodule
